// File: rtl/ft_add_pkg.sv
// Shared types and constants for the fault-tolerant add/subtract unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ft_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Two-rail status: only these two codes are ever driven.
  localparam logic [1:0] ERR_GOOD = 2'b10;
  localparam logic [1:0] ERR_BAD  = 2'b00;

  localparam logic [2:0] OP_ADD  = 3'b001;  // a + b
  localparam logic [2:0] OP_SUBA = 3'b010;  // a - b
  localparam logic [2:0] OP_SUBB = 3'b100;  // b - a

  // True only for exactly one of the three legal opcodes.
  function automatic logic op_is_onehot(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUBA) || (op == OP_SUBB);
  endfunction

endpackage

// File: rtl/ft_add_lane.sv
// Ripple-carry adder lane with carry-parity prediction (perr flags a lane fault).
// Latency: combinational.
// Backpressure: none; the parent decides when the lane result is used.
module ft_add_lane
  import ft_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             fi,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             perr
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  // Ripple the carry chain; the fault flip lands before parity is checked so perr sees it.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    s[0] = s[0] ^ fi;
  end

  assign sum  = s;
  assign cout = c[WIDTH];
  // Sum parity must equal parity(a) ^ parity(b) ^ parity(carries into each bit).
  assign perr = (^s) ^ (^a) ^ (^b) ^ (^c[WIDTH-1:0]);

endmodule

// File: rtl/ft_adder_pipe.sv
// Fault-tolerant add/sub: parity/one-hot input check, duplicated lanes with retry (FT_ADD_TMR_EN: three voted lanes).
// Latency: out_valid 2 cycles after accept, +1 per retry (max 2+MAX_RETRY).
// Backpressure: one op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module ft_adder_pipe
  import ft_add_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             par,
  input  logic [2:0]       op,
  input  logic             fi_lane1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       err_code,
  output logic [15:0]      stat_retries
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
`ifdef FT_ADD_TMR_EN
  localparam int NL = 3;
`else
  localparam int NL = 2;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [2:0]       op_q, op_d;
  logic             bad_q, bad_d, cout_q, cout_d, ovld_q, ovld_d;
  logic [1:0]       err_q, err_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [15:0]      stat_q, stat_d;

  // Operand conditioning shared by all lanes.
  logic [WIDTH-1:0] a_c, b_c;
  logic             cin;
  assign a_c = a_q ^ {WIDTH{op_q[2]}};
  assign b_c = b_q ^ {WIDTH{op_q[1]}};
  assign cin = op_q[1] | op_q[2];

  logic [WIDTH-1:0] lane_sum  [NL];
  logic [NL-1:0]    lane_cout;
  logic [NL-1:0]    lane_perr;
  logic [NL-1:0]    lane_fi;

  // Fault injection reaches lane 1 only while computing.
  always_comb begin
    lane_fi    = '0;
    lane_fi[1] = fi_lane1 & (state_q == EXEC);
  end

  for (genvar g = 0; g < NL; g++) begin : g_lane
    ft_add_lane #(.WIDTH(WIDTH)) u_lane (
      .a    (a_c),
      .b    (b_c),
      .cin  (cin),
      .fi   (lane_fi[g]),
      .sum  (lane_sum[g]),
      .cout (lane_cout[g]),
      .perr (lane_perr[g])
    );
  end

  logic [WIDTH:0] r0, r1, voted;
  logic           mismatch;
  assign r0 = {lane_cout[0], lane_sum[0]};
  assign r1 = {lane_cout[1], lane_sum[1]};

`ifdef FT_ADD_TMR_EN
  logic [WIDTH:0] r2;
  logic           ag01, ag02, ag12;
  assign r2 = {lane_cout[2], lane_sum[2]};
  // Vote among parity-clean lanes: any agreeing clean pair carries the majority value.
  always_comb begin
    ag01     = ~lane_perr[0] & ~lane_perr[1] & (r0 == r1);
    ag02     = ~lane_perr[0] & ~lane_perr[2] & (r0 == r2);
    ag12     = ~lane_perr[1] & ~lane_perr[2] & (r1 == r2);
    voted    = (ag01 | ag02) ? r0 : r1;
    mismatch = ~(ag01 | ag02 | ag12);
  end
`else
  // Duplication: any lane disagreement or parity error forces a retry.
  always_comb begin
    voted    = r0;
    mismatch = (r0 != r1) | lane_perr[0] | lane_perr[1];
  end
`endif

  // Next-state and handshake logic; outputs come straight from registers.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    bad_d    = bad_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    err_d    = err_q;
    ovld_d   = ovld_q;
    retry_d  = retry_q;
    stat_d   = stat_q;
    in_ready = (state_q == IDLE) & ~rst;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          bad_d   = ~((^a) ^ (^b) ^ par) | ~op_is_onehot(op);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (bad_q) begin
          sum_d   = '0;
          cout_d  = 1'b0;
          err_d   = ERR_BAD;
          ovld_d  = 1'b1;
          state_d = DONE;
        end else if (!mismatch) begin
          {cout_d, sum_d} = voted;
          err_d   = ERR_GOOD;
          ovld_d  = 1'b1;
          state_d = DONE;
        end else if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          if (stat_q != 16'hFFFF) stat_d = stat_q + 16'd1;
        end else begin
          {cout_d, sum_d} = r0;
          err_d   = ERR_BAD;
          ovld_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          ovld_d  = 1'b0;
          retry_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      bad_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= ERR_BAD;
      ovld_q  <= 1'b0;
      retry_q <= '0;
      stat_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      bad_q   <= bad_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      ovld_q  <= ovld_d;
      retry_q <= retry_d;
      stat_q  <= stat_d;
    end
  end

  assign out_valid    = ovld_q;
  assign sum          = sum_q;
  assign cout         = cout_q;
  assign err_code     = err_q;
  assign stat_retries = stat_q;

endmodule

// File: tb/tb_ft_adder_pipe.sv
// Directed bench for ft_adder_pipe (WIDTH=8, MAX_RETRY=2).
// Latency is counted from the accept cycle (cycle 0) to the cycle out_valid is seen.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_ft_adder_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a, b;
  logic        par;
  logic [2:0]  op;
  logic        fi_lane1;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  sum;
  logic        cout;
  logic [1:0]  err_code;
  logic [15:0] stat_retries;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_stat = 0;

  always #5 clk = ~clk;

  ft_adder_pipe #(.WIDTH(8), .MAX_RETRY(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .par          (par),
    .op           (op),
    .fi_lane1     (fi_lane1),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sum          (sum),
    .cout         (cout),
    .err_code     (err_code),
    .stat_retries (stat_retries)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // fim: 0 = no fault, 1 = fault for the first EXEC cycle, 2 = fault held throughout.
  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic tp, input logic [2:0] to, input int fim,
                       input logic [7:0] es, input logic ec, input logic [1:0] ee,
                       input int el);
    int lat;
    a = ta; b = tb_v; par = tp; op = to; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    fi_lane1 = (fim != 0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (fim == 1) fi_lane1 = 1'b0;
    end
    fi_lane1 = 1'b0;
    chk({tag, ".lat"},  32'(lat),  32'(el));
    chk({tag, ".sum"},  32'(sum),  32'(es));
    chk({tag, ".cout"}, 32'(cout), 32'(ec));
    chk({tag, ".err"},  32'(err_code), 32'(ee));
    chk({tag, ".stat"}, 32'(stat_retries), 32'(exp_stat));
    @(posedge clk); #1;
    chk({tag, ".drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; par = 1'b0; op = '0;
    fi_lane1 = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd0);
    chk("rst.sum",       32'(sum),       32'd0);
    chk("rst.err",       32'(err_code),  32'd0);
    chk("rst.stat",      32'(stat_retries), 32'd0);
    rst = 1'b0;

    // Plain arithmetic.
    do_op("add",   8'h5A, 8'h33, 1'b1, 3'b001, 0, 8'h8D, 1'b0, 2'b10, 2);
    do_op("suba1", 8'h10, 8'h20, 1'b1, 3'b010, 0, 8'hF0, 1'b0, 2'b10, 2);
    do_op("suba2", 8'h20, 8'h10, 1'b1, 3'b010, 0, 8'h10, 1'b1, 2'b10, 2);
    do_op("subb",  8'h10, 8'h20, 1'b1, 3'b100, 0, 8'h10, 1'b1, 2'b10, 2);
    do_op("wrap",  8'hFF, 8'h01, 1'b0, 3'b001, 0, 8'h00, 1'b1, 2'b10, 2);

    // Input-check failures: no retry, zeroed result, bad status.
    do_op("badpar", 8'h5A, 8'h33, 1'b0, 3'b001, 0, 8'h00, 1'b0, 2'b00, 2);
    do_op("op011",  8'h5A, 8'h33, 1'b1, 3'b011, 0, 8'h00, 1'b0, 2'b00, 2);
    do_op("op000",  8'h5A, 8'h33, 1'b1, 3'b000, 0, 8'h00, 1'b0, 2'b00, 2);

    // Lane-1 faults.
`ifdef FT_ADD_TMR_EN
    do_op("fi_pulse", 8'h5A, 8'h33, 1'b1, 3'b001, 1, 8'h8D, 1'b0, 2'b10, 2);
    do_op("fi_held",  8'h5A, 8'h33, 1'b1, 3'b001, 2, 8'h8D, 1'b0, 2'b10, 2);
`else
    exp_stat = 1;
    do_op("fi_pulse", 8'h5A, 8'h33, 1'b1, 3'b001, 1, 8'h8D, 1'b0, 2'b10, 3);
    exp_stat = 3;
    do_op("fi_held",  8'h5A, 8'h33, 1'b1, 3'b001, 2, 8'h8D, 1'b0, 2'b00, 4);
`endif

    // Backpressure: result must hold while out_ready is low.
    a = 8'h5A; b = 8'h33; par = 1'b1; op = 3'b001; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    begin
      int w;
      w = 0;
      while (!out_valid && w < 20) begin
        @(posedge clk); #1;
        w++;
      end
      chk("bp.valid", 32'(out_valid), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.hold_valid", 32'(out_valid), 32'd1);
      chk("bp.hold_sum",   32'(sum),       32'h8D);
      chk("bp.hold_err",   32'(err_code),  32'd2);
      chk("bp.in_ready",   32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.release_valid", 32'(out_valid), 32'd0);
    chk("bp.release_rdy",   32'(in_ready),  32'd1);

    // Reset while in EXEC abandons the operation.
    a = 8'h5A; b = 8'h33; par = 1'b1; op = 3'b001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstx.out_valid", 32'(out_valid), 32'd0);
    chk("rstx.in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    #1;
    chk("rstx.in_ready_after", 32'(in_ready), 32'd1);
    chk("rstx.stat",           32'(stat_retries), 32'd0);
    chk("rstx.err",            32'(err_code), 32'd0);
    @(posedge clk); #1;
    chk("rstx.no_output", 32'(out_valid), 32'd0);

    exp_stat = 0;
    do_op("post_rst", 8'h5A, 8'h33, 1'b1, 3'b001, 0, 8'h8D, 1'b0, 2'b10, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop if the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
